seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
//  It scans the digits at a programmable refresh rate, with per-digit hex value, dot and blank.
//  PWM brightness control and an anti-ghosting guard interval are included.

---
 rtl/seg7_scan_driver.sv | 128 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with PWM brightness,
// a per-slot anti-ghosting guard and tear-free, frame-aligned data updates.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dots_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load_in,
    input  logic [BRIGHT_W-1:0]     brightness_in,
    input  logic                    enable_in,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT,
    output logic                    frame_tick_out
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] S_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] GUARD_S = SW'(GUARD);
    localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    logic [SW-1:0] s_q, s_d;
    logic [DW-1:0] d_q, d_d;
    logic [NUM_DIGITS-1:0][3:0] live_dig_q, live_dig_d, pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0] live_dot_q, live_dot_d, pend_dot_q, pend_dot_d;
    logic [NUM_DIGITS-1:0] live_blank_q, live_blank_d, pend_blank_q, pend_blank_d;
    logic pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0] seg_q, seg_d;
    logic [7:0] hex_q, hex_d;
    logic tick_q, tick_d;
    logic s_last, frame_end, anode_on, pwm_on;

    always_comb begin
        s_d          = s_q;
        d_d          = d_q;
        live_dig_d   = live_dig_q;
        live_dot_d   = live_dot_q;
        live_blank_d = live_blank_q;
        pend_dig_d   = pend_dig_q;
        pend_dot_d   = pend_dot_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;
        seg_d        = '1;
        hex_d        = 8'hFF;

        s_last    = (s_q == S_LAST);
        frame_end = s_last && (d_q == D_LAST);
        tick_d    = frame_end;

        s_d = s_last ? '0 : s_q + 1'b1;
        if (s_last) d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;

        // Commit sees the pre-edge pending copy; a same-cycle load refills it afterwards.
        if (frame_end && pend_vld_q) begin
            live_dig_d   = pend_dig_q;
            live_dot_d   = pend_dot_q;
            live_blank_d = pend_blank_q;
            pend_vld_d   = 1'b0;
        end
        if (load_in) begin
            pend_dig_d   = digits_in;
            pend_dot_d   = dots_in;
            pend_blank_d = blank_in;
            pend_vld_d   = 1'b1;
        end

        pwm_on   = (brightness_in == '1) || (s_q[BRIGHT_W-1:0] < brightness_in);
        anode_on = enable_in && !live_blank_q[d_q] && (s_q >= GUARD_S) && pwm_on;
        if (anode_on) begin
            seg_d[d_q] = 1'b0;
            hex_d      = {~live_dot_q[d_q], seg7(live_dig_q[d_q])};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            s_q          <= '0;
            d_q          <= '0;
            live_dig_q   <= '0;
            live_dot_q   <= '0;
            live_blank_q <= '1;
            pend_dig_q   <= '0;
            pend_dot_q   <= '0;
            pend_blank_q <= '1;
            pend_vld_q   <= 1'b0;
            seg_q        <= '1;
            hex_q        <= 8'hFF;
            tick_q       <= 1'b0;
        end else begin
            s_q          <= s_d;
            d_q          <= d_d;
            live_dig_q   <= live_dig_d;
            live_dot_q   <= live_dot_d;
            live_blank_q <= live_blank_d;
            pend_dig_q   <= pend_dig_d;
            pend_dot_q   <= pend_dot_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            hex_q        <= hex_d;
            tick_q       <= tick_d;
        end
    end

    assign SEG_SELECT_OUT = seg_q;
    assign HEX_OUT        = hex_q;
    assign frame_tick_out = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a time-indexed model predicts each cycle's outputs into a
// queue; a negedge monitor pops and compares against the DUT.
module tb_seg7_scan_driver;
    localparam int ND = 4, RD = 8, G = 2, BW = 2, FR = ND * RD;
    localparam logic [6:0] SEG_T [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk_sys = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0] dots_in = '0, blank_in = '0;
    logic load_in = 1'b0;
    logic [1:0] brightness_in = 2'd3;
    logic enable_in = 1'b1;
    logic [3:0] seg_out;
    logic [7:0] hex_out;
    logic tick_out;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(G), .BRIGHT_W(BW)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .digits_in(digits_in), .dots_in(dots_in),
        .blank_in(blank_in), .load_in(load_in), .brightness_in(brightness_in),
        .enable_in(enable_in), .SEG_SELECT_OUT(seg_out), .HEX_OUT(hex_out),
        .frame_tick_out(tick_out));

    always #5 clk_sys = ~clk_sys;

    typedef struct packed { logic [3:0] seg; logic [7:0] hex; logic tick; } exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0;

    // Model: t = cycles since reset release; slot and digit follow from t directly.
    int t = 0;
    logic [3:0] m_dig[ND], p_dig[ND];
    logic [3:0] m_dot = '0, m_blank = '1, p_dot = '0, p_blank = '1;
    bit p_vld = 0;

    task automatic step();
        exp_t e;
        int s, d;
        bit on;
        logic [3:0] one = 4'b0001;
        if (!rst_n) begin
            e.seg = 4'hF; e.hex = 8'hFF; e.tick = 1'b0;
            t = 0; m_dot = '0; m_blank = '1; p_vld = 0;
            for (int i = 0; i < ND; i++) m_dig[i] = '0;
        end else begin
            s = t % RD;
            d = (t / RD) % ND;
            on = enable_in && !m_blank[d] && s >= G && (brightness_in == 2'd3 || (s % 4) < int'(brightness_in));
            e.seg  = on ? ~(one << d) : 4'hF;
            e.hex  = on ? {~m_dot[d], SEG_T[m_dig[d]]} : 8'hFF;
            e.tick = ((t % FR) == FR - 1);
            if (e.tick && p_vld) begin
                for (int i = 0; i < ND; i++) m_dig[i] = p_dig[i];
                m_dot = p_dot; m_blank = p_blank; p_vld = 0;
            end
            if (load_in) begin
                for (int i = 0; i < ND; i++) p_dig[i] = digits_in[4*i +: 4];
                p_dot = dots_in; p_blank = blank_in; p_vld = 1;
            end
            t++;
        end
        exp_q.push_back(e);
        @(negedge clk_sys); #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until(input int phase);
        int guard_cnt = 0;
        while ((t % FR) != phase && guard_cnt < 2 * FR) begin step(); guard_cnt++; end
    endtask

    task automatic load(input logic [15:0] dg, input logic [3:0] dt, input logic [3:0] bl);
        digits_in = dg; dots_in = dt; blank_in = bl; load_in = 1'b1;
        step();
        load_in = 1'b0;
    endtask

    exp_t ex;
    always @(negedge clk_sys) begin
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            checks += 4;
            if (seg_out !== ex.seg) begin
                errors++;
                $display("FAIL seg t=%0t got %b exp %b", $time, seg_out, ex.seg);
            end
            if (hex_out !== ex.hex) begin
                errors++;
                $display("FAIL hex t=%0t got %h exp %h", $time, hex_out, ex.hex);
            end
            if (tick_out !== ex.tick) begin
                errors++;
                $display("FAIL tick t=%0t got %b exp %b", $time, tick_out, ex.tick);
            end
            if ($countones(~seg_out) > 1) begin
                errors++;
                $display("FAIL one_anode t=%0t got %b exp at most one low", $time, seg_out);
            end
        end
    end

    initial begin
        @(negedge clk_sys); #1;
        // Reset held, then idle dark frames
        run(3);
        rst_n = 1'b1;
        run(2 * FR);
        // Pattern CA80 with dots, full brightness
        load(16'hCA80, 4'b1010, 4'b0000);
        run(3 * FR);
        // PWM duty levels
        brightness_in = 2'd1; run(FR);
        brightness_in = 2'd0; run(FR);
        brightness_in = 2'd2; run(FR);
        brightness_in = 2'd3;
        // Mid-frame load then boundary-cycle load: 1s frame, then 2s frame
        run_until(10);
        load(16'h1111, 4'b0000, 4'b0000);
        run_until(FR - 1);
        load(16'h2222, 4'b0001, 4'b0000);
        run(3 * FR);
        // Boundary-cycle load with nothing pending waits a full extra frame
        run_until(FR - 1);
        load(16'h3456, 4'b0000, 4'b0000);
        run(2 * FR);
        // Blanked digit, then enable off/on
        load(16'h9876, 4'b1111, 4'b0100);
        run(2 * FR);
        enable_in = 1'b0; run(FR + 5);
        enable_in = 1'b1; run(FR + 11);
        // Reset mid-slot of digit 2 with a pending load outstanding
        run_until(17);
        load(16'h5555, 4'b0000, 4'b0000);
        run_until(2 * RD + 4);
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        run(FR + 8);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                digits_in = 16'($urandom); dots_in = 4'($urandom); blank_in = 4'($urandom);
                load_in = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) brightness_in = 2'($urandom);
            enable_in = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            step();
            load_in = 1'b0;
            rst_n = 1'b1;
        end
        run(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
